// File: rtl/lab_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// Holds the FSM state encoding and requester index constants.
package lab_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// WIDTH-bit 2:1 mux; purely combinational, zero latency, no flow control of its own.
module mux2_w #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] out,
    input  logic             s,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1
);

    assign out = s ? i1 : i0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin controller for a shared 2:1 mux: grant 1 cycle after request, zero-bubble switching.
// Backpressure: out_ready gates acks; beats only count accepted transfers, so a stall never forces a switch.
module mux_rr_arbiter
    import lab_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam logic [BW-1:0] BEATS_MAX  = BW'(MAX_BEATS);
    localparam logic [BW-1:0] BEATS_LAST = BW'(MAX_BEATS - 1);

    arb_state_t    state, state_nxt;
    arb_state_t    oth_state;
    logic          last, last_nxt;
    logic [BW-1:0] beats, beats_nxt;
    logic          sel_q, sel_nxt;
    logic          own_idx, own_req, oth_req, own_ack;

    assign gnt0      = (state == GNT0);
    assign gnt1      = (state == GNT1);
    assign ack0      = gnt0 & req0 & out_ready;
    assign ack1      = gnt1 & req1 & out_ready;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign sel       = sel_q;

    mux2_w #(.WIDTH(WIDTH)) u_mux (
        .out (out_data),
        .s   (sel_q),
        .i0  (data0),
        .i1  (data1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= REQ_1;
            beats <= '0;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            beats <= beats_nxt;
            sel_q <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        beats_nxt = beats;
        sel_nxt   = sel_q;
        own_idx   = (state == GNT1) ? REQ_1 : REQ_0;
        own_req   = (state == GNT1) ? req1 : req0;
        oth_req   = (state == GNT1) ? req0 : req1;
        own_ack   = ack0 | ack1;
        oth_state = (state == GNT0) ? GNT1 : GNT0;

        case (state)
            IDLE: begin
                beats_nxt = '0;
                // On a tie, the requester that was not served last wins.
                if (req0 && (!req1 || last == REQ_1)) begin
                    state_nxt = GNT0;
                    sel_nxt   = REQ_0;
                end else if (req1) begin
                    state_nxt = GNT1;
                    sel_nxt   = REQ_1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req) begin
                    last_nxt  = own_idx;
                    beats_nxt = '0;
                    if (oth_req) begin
                        state_nxt = oth_state;
                        sel_nxt   = ~own_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (own_ack) begin
                    // This transfer brings the count to MAX_BEATS: hand over if
                    // someone is waiting, otherwise saturate and keep the grant.
                    if (beats >= BEATS_LAST) begin
                        if (oth_req) begin
                            state_nxt = oth_state;
                            sel_nxt   = ~own_idx;
                            last_nxt  = own_idx;
                            beats_nxt = '0;
                        end else begin
                            beats_nxt = BEATS_MAX;
                        end
                    end else begin
                        beats_nxt = beats + BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beats_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, directed corner sequences, random vs reference model.
module tb_mux_rr_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, ack0, ack1, sel, out_valid;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: who owns the channel, who was served last, beats taken in this grant.
    int   m_owner = -1;
    int   m_last  = 1;
    int   m_cnt   = 0;
    logic m_sel   = 1'b0;

    int   ack0_seen = 0, ack1_seen = 0;
    logic s_g0, s_g1, s_sel, s_ov;
    logic [W-1:0] s_dat;

    typedef struct {
        logic         r0;
        logic         r1;
        logic         rdy;
        logic [5:0]   exp_ctl;   // {gnt0,gnt1,ack0,ack1,sel,out_valid}
        logic [W-1:0] exp_dat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [13:0] dut_vec();
        return {gnt0, gnt1, ack0, ack1, sel, out_valid, out_data};
    endfunction

    function automatic logic [13:0] model_vec();
        logic g0, g1, a0, a1, ov;
        logic [W-1:0] od;
        g0 = (m_owner == 0);
        g1 = (m_owner == 1);
        a0 = g0 & req0 & out_ready;
        a1 = g1 & req1 & out_ready;
        ov = (g0 & req0) | (g1 & req1);
        od = m_sel ? data1 : data0;
        return {g0, g1, a0, a1, m_sel, ov, od};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
        m_sel   = 1'b0;
    endtask

    task automatic model_step();
        int   i;
        logic own, oth;
        if (m_owner < 0) begin
            if (req0 && req1)  m_owner = 1 - m_last;
            else if (req0)     m_owner = 0;
            else if (req1)     m_owner = 1;
            if (m_owner >= 0) m_sel = (m_owner == 1);
            m_cnt = 0;
        end else begin
            i   = m_owner;
            own = (i == 0) ? req0 : req1;
            oth = (i == 0) ? req1 : req0;
            if (!own) begin
                m_last  = i;
                m_cnt   = 0;
                m_owner = oth ? 1 - i : -1;
                if (oth) m_sel = (i == 0);
            end else if (out_ready) begin
                m_cnt++;
                if (oth && m_cnt >= MB) begin
                    m_owner = 1 - i;
                    m_last  = i;
                    m_cnt   = 0;
                    m_sel   = (i == 0);
                end
            end
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic rdy,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
        req0 = r0; req1 = r1; out_ready = rdy; data0 = d0; data1 = d1;
    endtask

    // Drive, compare against the model mid-cycle, then advance the model across the edge.
    task automatic cycle(input string name, input logic r0, input logic r1, input logic rdy,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
        drive(r0, r1, rdy, d0, d1);
        @(negedge clk);
        check(name, 16'(dut_vec()), 16'(model_vec()));
        s_g0 = gnt0; s_g1 = gnt1; s_sel = sel; s_ov = out_valid; s_dat = out_data;
        if (ack0) ack0_seen++;
        if (ack1) ack1_seen++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 6'b000000, 8'h11};
        for (int k = 1; k <= 4; k++) tbl[k] = '{1'b1, 1'b1, 1'b1, 6'b101001, 8'h11};
        for (int k = 5; k <= 8; k++) tbl[k] = '{1'b1, 1'b1, 1'b1, 6'b010111, 8'h22};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 6'b101001, 8'h11};

        // Reset values
        drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        @(negedge clk);
        check("reset_outs", {10'd0, gnt0, gnt1, ack0, ack1, sel, out_valid}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Fairness: groups of MAX_BEATS with no idle cycle between them
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].r0, tbl[k].r1, tbl[k].rdy, 8'h11, 8'h22);
            @(negedge clk);
            check($sformatf("fair_tbl[%0d]", k),
                  {2'b00, gnt0, gnt1, ack0, ack1, sel, out_valid, out_data},
                  {2'b00, tbl[k].exp_ctl, tbl[k].exp_dat});
            @(posedge clk);
            model_step();
            #1;
        end

        // Reset mid-grant while requester 1 owns the mux (sel=1)
        for (int k = 0; k < 4; k++) cycle("fair_tail", 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        #2;
        check("pre_rst_gnt1", {14'd0, gnt0, gnt1}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {10'd0, gnt0, gnt1, ack0, ack1, sel, out_valid}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle("rst_rel_idle", 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        cycle("rst_rel_gnt", 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        check("rst_first_gnt0", {14'd0, s_g0, s_g1}, 16'd2);

        // Single requester streams indefinitely
        cycle("to_idle", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cycle("to_idle", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        ack0_seen = 0; ack1_seen = 0;
        for (int k = 0; k < 11; k++) cycle("single", 1'b0, 1'b1, 1'b1, 8'h00, 8'hA5);
        check("single_ack1_cnt", 16'(ack1_seen), 16'd10);
        check("single_data", {8'd0, s_dat}, 16'h00A5);

        // Backpressure: only accepted beats count toward the switch
        cycle("bp_idle", 1'b0, 1'b0, 1'b0, 8'h3C, 8'h99);
        cycle("bp_start", 1'b1, 1'b0, 1'b0, 8'h3C, 8'h99);
        ack0_seen = 0; ack1_seen = 0;
        for (int k = 0; k < 7; k++) cycle("bp", 1'b1, 1'b1, (k % 2) == 0, 8'h3C, 8'h99);
        check("bp_ack0_cnt", 16'(ack0_seen), 16'd4);
        cycle("bp_switch", 1'b1, 1'b1, 1'b1, 8'h3C, 8'h99);
        check("bp_gnt1", {14'd0, s_g0, s_g1}, 16'd1);

        // Early release hands over the next cycle
        cycle("er_idle", 1'b0, 1'b0, 1'b1, 8'h44, 8'h55);
        cycle("er_start", 1'b1, 1'b0, 1'b1, 8'h44, 8'h55);
        cycle("er_beat", 1'b1, 1'b1, 1'b1, 8'h44, 8'h55);
        cycle("er_beat", 1'b1, 1'b1, 1'b1, 8'h44, 8'h55);
        cycle("er_drop", 1'b0, 1'b1, 1'b1, 8'h44, 8'h55);
        cycle("er_next", 1'b0, 1'b1, 1'b1, 8'h44, 8'h55);
        check("er_gnt1", {14'd0, s_g0, s_g1}, 16'd1);

        // Idle return keeps sel
        cycle("idle_drop", 1'b0, 1'b0, 1'b1, 8'h44, 8'h55);
        cycle("idle_hold", 1'b0, 1'b0, 1'b1, 8'h44, 8'h55);
        check("idle_ret", {12'd0, s_g0, s_g1, s_sel, s_ov}, 16'b0010);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            cycle("rand",
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) != 0,
                  W'($urandom),
                  W'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
